// File: rtl/newbyte_lane_assembler.sv
`default_nettype none
// ============================================================================
// Module  : newbyte_lane_assembler
// Brief   : Routes a byte stream into NDEST lane-assembled word registers with
//           registered strobes, per-destination lane counters and completion.
// Revision: 1.0 - initial release
// ============================================================================
module newbyte_lane_assembler #(
  parameter int NLANE = 4,
  parameter int BW    = 8,
  parameter int NDEST = 2
) (
  input  logic                                  phi3,
  input  logic                                  reset,
  input  logic                                  byte_in_valid,
  input  logic [BW-1:0]                         byte_in,
  input  logic [((NDEST > 1) ? $clog2(NDEST) : 1)-1:0] dest,
  input  logic [$clog2(NLANE)-1:0]              lane,
  input  logic                                  auto_lane,
  input  logic                                  pass,
  input  logic                                  flush,
  output logic [NDEST*NLANE-1:0]                strobe,
  output logic [NDEST*NLANE*BW-1:0]             word,
  output logic [NDEST*NLANE-1:0]                lane_mask,
  output logic [NDEST-1:0]                      word_valid,
  output logic [NDEST-1:0]                      overwrite_err
);

  localparam int LW = $clog2(NLANE);
  localparam int DW = (NDEST > 1) ? $clog2(NDEST) : 1;

  logic [BW-1:0]    r_word   [NDEST][NLANE];
  logic [NLANE-1:0] r_mask   [NDEST];
  logic [NLANE-1:0] r_strobe [NDEST];
  logic [LW-1:0]    r_cnt    [NDEST];
  logic [NDEST-1:0] r_word_valid;
  logic [NDEST-1:0] r_overwrite;

  logic             w_dest_ok;
  logic             w_accept;
  logic [LW-1:0]    w_lane;
  logic [NLANE-1:0] w_onehot;
  logic [NLANE-1:0] w_mask_cur;
  logic             w_full;
  logic             w_overwrite;

  // Non-power-of-two NDEST leaves dest codes with no backing register.
  assign w_dest_ok   = ({1'b0, dest} < (DW+1)'(NDEST));
  assign w_accept    = byte_in_valid & ~pass & ~flush & w_dest_ok;
  assign w_lane      = auto_lane ? r_cnt[dest] : lane;
  assign w_onehot    = NLANE'(1) << w_lane;
  assign w_mask_cur  = r_mask[dest];
  assign w_full      = &(w_mask_cur | w_onehot);
  assign w_overwrite = |(w_mask_cur & w_onehot);

  always_ff @(posedge phi3 or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < NDEST; d++) begin
        for (int k = 0; k < NLANE; k++) r_word[d][k] <= '0;
        r_mask[d]   <= '0;
        r_strobe[d] <= '0;
        r_cnt[d]    <= '0;
      end
      r_word_valid <= '0;
      r_overwrite  <= '0;
    end else begin
      for (int d = 0; d < NDEST; d++) r_strobe[d] <= '0;
      r_word_valid <= '0;
      r_overwrite  <= '0;
      if (flush) begin
        // Abort partial words only; assembled data stays visible.
        for (int d = 0; d < NDEST; d++) begin
          r_mask[d] <= '0;
          r_cnt[d]  <= '0;
        end
      end else if (w_accept) begin
        r_word[dest][w_lane] <= byte_in;
        r_strobe[dest]       <= w_onehot;
        r_overwrite[dest]    <= w_overwrite;
        if (w_full) begin
          r_mask[dest]       <= '0;
          r_cnt[dest]        <= '0;
          r_word_valid[dest] <= 1'b1;
        end else begin
          r_mask[dest] <= w_mask_cur | w_onehot;
          r_cnt[dest]  <= w_lane + 1'b1;
        end
      end
    end
  end

  for (genvar d = 0; d < NDEST; d++) begin : g_dest
    assign strobe[d*NLANE +: NLANE]    = r_strobe[d];
    assign lane_mask[d*NLANE +: NLANE] = r_mask[d];
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
      assign word[(d*NLANE+k)*BW +: BW] = r_word[d][k];
    end
  end

  assign word_valid    = r_word_valid;
  assign overwrite_err = r_overwrite;

endmodule
`default_nettype wire

// File: tb/tb_newbyte_lane_assembler.sv
`default_nettype none
// ============================================================================
// Module  : tb_newbyte_lane_assembler
// Brief   : Directed and random stimulus against a lane-array reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_newbyte_lane_assembler;

  localparam int NLANE = 4;
  localparam int BW    = 8;
  localparam int NDEST = 3;
  localparam int DW    = 2;
  localparam int LW    = 2;

  logic                      phi3 = 1'b0;
  logic                      reset;
  logic                      byte_in_valid;
  logic [BW-1:0]             byte_in;
  logic [DW-1:0]             dest;
  logic [LW-1:0]             lane;
  logic                      auto_lane;
  logic                      pass;
  logic                      flush;
  logic [NDEST*NLANE-1:0]    strobe;
  logic [NDEST*NLANE*BW-1:0] word;
  logic [NDEST*NLANE-1:0]    lane_mask;
  logic [NDEST-1:0]          word_valid;
  logic [NDEST-1:0]          overwrite_err;

  newbyte_lane_assembler #(.NLANE(NLANE), .BW(BW), .NDEST(NDEST)) u_dut (
    .phi3(phi3), .reset(reset), .byte_in_valid(byte_in_valid), .byte_in(byte_in),
    .dest(dest), .lane(lane), .auto_lane(auto_lane), .pass(pass), .flush(flush),
    .strobe(strobe), .word(word), .lane_mask(lane_mask), .word_valid(word_valid),
    .overwrite_err(overwrite_err)
  );

  always #5 phi3 = ~phi3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: words as byte arrays, filled lanes as flags, counters as ints.
  logic [BW-1:0]          m_word [NDEST][NLANE];
  bit                     m_fill [NDEST][NLANE];
  int                     m_cnt  [NDEST];
  logic [NDEST*NLANE-1:0] e_strobe;
  logic [NDEST-1:0]       e_wv, e_ovr;

  task automatic model_reset();
    for (int d = 0; d < NDEST; d++) begin
      for (int k = 0; k < NLANE; k++) begin m_word[d][k] = '0; m_fill[d][k] = 0; end
      m_cnt[d] = 0;
    end
    e_strobe = '0; e_wv = '0; e_ovr = '0;
  endtask

  task automatic compare_all(input string tag);
    logic [NDEST*NLANE*BW-1:0] ew;
    logic [NDEST*NLANE-1:0]    em;
    for (int d = 0; d < NDEST; d++)
      for (int k = 0; k < NLANE; k++) begin
        ew[(d*NLANE+k)*BW +: BW] = m_word[d][k];
        em[d*NLANE+k]            = m_fill[d][k];
      end
    check({tag, "_strobe"}, 128'(strobe), 128'(e_strobe));
    check({tag, "_word"}, 128'(word), 128'(ew));
    check({tag, "_mask"}, 128'(lane_mask), 128'(em));
    check({tag, "_wv"}, 128'(word_valid), 128'(e_wv));
    check({tag, "_ovr"}, 128'(overwrite_err), 128'(e_ovr));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input bit v, input logic [7:0] b, input int d,
                      input int l, input bit a, input bit p, input bit f);
    int  ln;
    bit  full;
    byte_in_valid = v; byte_in = b; dest = DW'(d); lane = LW'(l);
    auto_lane = a; pass = p; flush = f;
    @(posedge phi3);
    e_strobe = '0; e_wv = '0; e_ovr = '0;
    if (f) begin
      for (int i = 0; i < NDEST; i++) begin
        m_cnt[i] = 0;
        for (int k = 0; k < NLANE; k++) m_fill[i][k] = 0;
      end
    end else if (v && !p && d < NDEST) begin
      ln = a ? m_cnt[d] : l;
      e_ovr[d] = m_fill[d][ln];
      m_word[d][ln] = b;
      m_fill[d][ln] = 1;
      e_strobe[d*NLANE+ln] = 1'b1;
      full = 1;
      for (int k = 0; k < NLANE; k++) full &= m_fill[d][k];
      if (full) begin
        e_wv[d] = 1'b1;
        m_cnt[d] = 0;
        for (int k = 0; k < NLANE; k++) m_fill[d][k] = 0;
      end else begin
        m_cnt[d] = (ln + 1) % NLANE;
      end
    end
    #1 compare_all(tag);
    @(negedge phi3);
  endtask

  initial begin
    reset = 1'b1; byte_in_valid = 0; byte_in = '0; dest = '0; lane = '0;
    auto_lane = 0; pass = 0; flush = 0;
    model_reset();
    @(negedge phi3); @(negedge phi3);
    compare_all("reset");
    reset = 1'b0;
    @(negedge phi3);

    // Auto fill into EX
    step("t1_b0", 1, 8'h11, 1, 0, 1, 0, 0);
    check("t1_strobe0", 128'(strobe), 128'(12'h010));
    step("t1_b1", 1, 8'h22, 1, 0, 1, 0, 0);
    step("t1_b2", 1, 8'h33, 1, 0, 1, 0, 0);
    step("t1_b3", 1, 8'h44, 1, 0, 1, 0, 0);
    check("t1_word1", 128'(word[63:32]), 128'(32'h44332211));
    check("t1_wv", 128'(word_valid), 128'(3'b010));
    check("t1_word0", 128'(word[31:0]), 128'(0));

    // Pass suppression, then a real byte lands in lane 0
    step("t2_pass", 1, 8'hAA, 0, 0, 1, 1, 0);
    check("t2_no_strobe", 128'(strobe), 128'(0));
    step("t2_next", 1, 8'h5A, 0, 0, 1, 0, 0);
    check("t2_lane0", 128'(strobe), 128'(12'h001));
    step("t2_flush", 0, 8'h00, 0, 0, 0, 0, 1);

    // Explicit lanes with overwrite
    step("t3_l2a", 1, 8'hBE, 0, 2, 0, 0, 0);
    step("t3_l2b", 1, 8'hEF, 0, 2, 0, 0, 0);
    check("t3_ovr", 128'(overwrite_err), 128'(3'b001));
    check("t3_byte", 128'(word[23:16]), 128'(8'hEF));
    check("t3_mask", 128'(lane_mask[3:0]), 128'(4'b0100));
    step("t3_l0", 1, 8'h01, 0, 0, 0, 0, 0);
    step("t3_l1", 1, 8'h02, 0, 1, 0, 0, 0);
    step("t3_l3", 1, 8'h03, 0, 3, 0, 0, 0);
    check("t3_wv", 128'(word_valid), 128'(3'b001));
    check("t3_mask_clr", 128'(lane_mask), 128'(0));

    // Interleaved auto assembly
    for (int i = 1; i <= 8; i++) begin
      step("t4", 1, 8'(i), (i - 1) % 2, 0, 1, 0, 0);
      if (i == 7) check("t4_wv0", 128'(word_valid), 128'(3'b001));
      if (i == 8) check("t4_wv1", 128'(word_valid), 128'(3'b010));
    end
    check("t4_word0", 128'(word[31:0]), 128'(32'h07050301));
    check("t4_word1", 128'(word[63:32]), 128'(32'h08060402));

    // Flush drops the partial word and the byte offered with it
    step("t5_a", 1, 8'hA1, 1, 0, 1, 0, 0);
    step("t5_b", 1, 8'hA2, 1, 0, 1, 0, 0);
    step("t5_f", 1, 8'h55, 1, 0, 1, 0, 1);
    check("t5_flush_strobe", 128'(strobe), 128'(0));
    check("t5_flush_mask", 128'(lane_mask), 128'(0));
    for (int i = 1; i <= 4; i++) step("t5_fill", 1, 8'hB0 + 8'(i), 1, 0, 1, 0, 0);
    check("t5_word1", 128'(word[63:32]), 128'(32'hB4B3B2B1));
    check("t5_wv", 128'(word_valid), 128'(3'b010));

    // Asynchronous reset mid-fill
    for (int i = 1; i <= 3; i++) step("t6_pre", 1, 8'hC0 + 8'(i), 0, 0, 1, 0, 0);
    byte_in_valid = 0;
    #2 reset = 1'b1;
    #1 check("t6_async_word", 128'(word), 128'(0));
    check("t6_async_mask", 128'(lane_mask), 128'(0));
    model_reset();
    @(negedge phi3);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) step("t6_post", 1, 8'hD0 + 8'(i), 0, 0, 1, 0, 0);
    check("t6_wv", 128'(word_valid), 128'(3'b001));
    check("t6_word0", 128'(word[31:0]), 128'(32'hD4D3D2D1));

    // Random traffic, including the unbacked dest code 3
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
